// File: rtl/polygon_feeder.sv
// polygon_feeder: accepts polygon commands, builds the vertex set in a shadow bank and commits it to the stage-3 outputs.
// FEEDER_FRAME_SYNC_EN: when defined, commits wait for frame_start; otherwise they follow CALC directly.
module polygon_feeder #(
    parameter int FRAME_W = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_form,
    input  logic [FRAME_W-1:0] cmd_ref_x,
    input  logic [FRAME_W-1:0] cmd_ref_y,
    input  logic [3:0]         cmd_size,
    input  logic [8:0]         cmd_color,
    input  logic               frame_start,
    input  logic [FRAME_W-1:0] in_pixel_x,
    input  logic [FRAME_W-1:0] in_pixel_y,
    input  logic               in_blank,
    output logic [FRAME_W-1:0] v1_x,
    output logic [FRAME_W-1:0] v1_y,
    output logic [FRAME_W-1:0] v2_x,
    output logic [FRAME_W-1:0] v2_y,
    output logic [FRAME_W-1:0] v3_x,
    output logic [FRAME_W-1:0] v3_y,
    output logic [FRAME_W-1:0] v4_x,
    output logic [FRAME_W-1:0] v4_y,
    output logic               form,
    output logic [FRAME_W-1:0] st3_pixel_x,
    output logic [FRAME_W-1:0] st3_pixel_y,
    output logic [8:0]         st3_color,
    output logic               st3_bubble
);
    // Two guard bits keep ref+h (up to 1143) from wrapping before the clamp.
    localparam int CW = FRAME_W + 2;
    localparam logic signed [CW-1:0] MAX_C = {2'b00, {FRAME_W{1'b1}}};

    typedef enum logic [1:0] {IDLE, CALC, PEND} state_t;

    state_t                    state_q;
    logic                      form_q;
    logic [FRAME_W-1:0]        ref_x_q;
    logic [FRAME_W-1:0]        ref_y_q;
    logic [3:0]                size_q;
    logic [8:0]                color_q;
    logic [7:0][FRAME_W-1:0]   vert_d;
    logic [7:0][FRAME_W-1:0]   shadow_q;
    logic [7:0][FRAME_W-1:0]   out_q;
    logic                      sh_form_q;
    logic                      sh_active_q;
    logic [8:0]                sh_color_q;
    logic                      active_q;
    logic signed [CW-1:0]      x_s;
    logic signed [CW-1:0]      y_s;
    logic signed [CW-1:0]      h_s;
    logic [FRAME_W-1:0]        xm;
    logic [FRAME_W-1:0]        xp;
    logic [FRAME_W-1:0]        ym;
    logic [FRAME_W-1:0]        yp;
    logic                      commit_go;

    function automatic logic [FRAME_W-1:0] clamp(input logic signed [CW-1:0] v);
        return v[CW-1] ? {FRAME_W{1'b0}} : (v > MAX_C ? {FRAME_W{1'b1}} : v[FRAME_W-1:0]);
    endfunction

    assign x_s = signed'({2'b00, ref_x_q});
    assign y_s = signed'({2'b00, ref_y_q});
    assign h_s = signed'(CW'({size_q, 3'b000}));
    assign xm  = clamp(x_s - h_s);
    assign xp  = clamp(x_s + h_s);
    assign ym  = clamp(y_s - h_s);
    assign yp  = clamp(y_s + h_s);

    // Square winds v1..v4 counter-clockwise; triangle shares v2/v3 with the square and parks v4 at the origin.
    assign vert_d = {form_q ? ref_x_q : xm, ym, xm, yp, xp, yp,
                     form_q ? {FRAME_W{1'b0}} : xp, form_q ? {FRAME_W{1'b0}} : ym};

    assign cmd_ready = state_q == IDLE;
    assign {v1_x, v1_y, v2_x, v2_y, v3_x, v3_y, v4_x, v4_y} = out_q;

`ifdef FEEDER_FRAME_SYNC_EN
    assign commit_go = frame_start;
`else
    logic unused_frame_start;
    assign unused_frame_start = frame_start;
    assign commit_go = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            form_q      <= 1'b0;
            ref_x_q     <= '0;
            ref_y_q     <= '0;
            size_q      <= '0;
            color_q     <= '0;
            shadow_q    <= '0;
            sh_form_q   <= 1'b0;
            sh_active_q <= 1'b0;
            sh_color_q  <= '0;
            out_q       <= '0;
            active_q    <= 1'b0;
            form        <= 1'b0;
            st3_color   <= '0;
            st3_pixel_x <= '0;
            st3_pixel_y <= '0;
            st3_bubble  <= 1'b1;
        end else begin
            st3_pixel_x <= in_pixel_x;
            st3_pixel_y <= in_pixel_y;
            st3_bubble  <= !active_q | in_blank;
            case (state_q)
                IDLE: if (cmd_valid) begin
                    form_q  <= cmd_form;
                    ref_x_q <= cmd_ref_x;
                    ref_y_q <= cmd_ref_y;
                    size_q  <= cmd_size;
                    color_q <= cmd_color;
                    state_q <= CALC;
                end
                CALC: begin
                    shadow_q    <= vert_d;
                    sh_form_q   <= form_q;
                    sh_color_q  <= color_q;
                    sh_active_q <= size_q != 4'd0;
                    state_q     <= PEND;
                end
                PEND: if (commit_go) begin
                    out_q     <= shadow_q;
                    form      <= sh_form_q;
                    st3_color <= sh_color_q;
                    active_q  <= sh_active_q;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
